// File: rtl/ram_arbiter_if.sv
// Requester-side bus of ram_arbiter: two req/gnt ports with their read-return paths.
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              rvalid0;
  logic              rvalid1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM; one access per two cycles.
// Define ARB_FIXED_PRIO_EN for fixed priority to requester 0 (default: round-robin).
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      bus,
  output logic              ram_cs,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_start;
  logic              w_contend;
  logic              w_win1;
  logic              r_win;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_cs;
  logic              r_re;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic [15:0]       r_conflict_cnt;
`ifndef ARB_FIXED_PRIO_EN
  logic              r_last;
`endif

  // Winner select: w_win1 is meaningful only when a request is present.
  always_comb begin
    w_contend = bus.req0 & bus.req1;
`ifdef ARB_FIXED_PRIO_EN
    w_win1 = bus.req1 & ~bus.req0;
`else
    w_win1 = bus.req1 & (~bus.req0 | ~r_last);
`endif
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req0 | bus.req1) begin
          w_start     = 1'b1;
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant, RAM strobes and read return; strobes default low so every pulse lasts one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win     <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= {DATA_W{1'b0}};
      r_rdata1  <= {DATA_W{1'b0}};
      r_cs      <= 1'b0;
      r_re      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= {ADDR_W{1'b0}};
      r_wdata   <= {DATA_W{1'b0}};
      r_busy    <= 1'b0;
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_cs      <= 1'b0;
      r_re      <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      if (w_start) begin
        r_win  <= w_win1;
        r_gnt0 <= ~w_win1;
        r_gnt1 <= w_win1;
        r_cs   <= 1'b1;
        r_busy <= 1'b1;
        if (w_win1) begin
          r_we    <= bus.we1;
          r_re    <= ~bus.we1;
          r_addr  <= bus.addr1;
          r_wdata <= bus.wdata1;
        end else begin
          r_we    <= bus.we0;
          r_re    <= ~bus.we0;
          r_addr  <= bus.addr0;
          r_wdata <= bus.wdata0;
        end
      end else if ((r_state == ST_ACCESS) && r_re) begin
        if (r_win) begin
          r_rdata1  <= ram_rdata;
          r_rvalid1 <= 1'b1;
        end else begin
          r_rdata0  <= ram_rdata;
          r_rvalid0 <= 1'b1;
        end
      end else begin
        r_win <= r_win;
      end
    end
  end

  // Contention counter, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= 16'h0000;
    end else if (w_start && w_contend && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'h0001;
    end else begin
      r_conflict_cnt <= r_conflict_cnt;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  // Round-robin history: records the winner of the latest contention only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_start && w_contend) begin
      r_last <= w_win1;
    end else begin
      r_last <= r_last;
    end
  end
`endif

  assign bus.gnt0     = r_gnt0;
  assign bus.gnt1     = r_gnt1;
  assign bus.rvalid0  = r_rvalid0;
  assign bus.rvalid1  = r_rvalid1;
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;
  assign ram_cs       = r_cs;
  assign ram_re       = r_re;
  assign ram_we       = r_we;
  assign ram_addr     = r_addr;
  assign ram_wdata    = r_wdata;
  assign busy         = r_busy;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter placed in front of the single-port data `Ram`, sharing it between the main `controller` (requester 0) and a secondary master such as a port-capture/DMA engine (requester 1). It accepts word read/write requests on a req/gnt handshake, picks one winner per access with round-robin fairness, and drives the RAM's chip-select, read-enable, write-enable, address and data lines. It returns read data with a one-cycle valid pulse to the winning requester.

## Interface
Parameters:
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 16: RAM data width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  access request; held high, with its fields stable, until the matching `gnt`.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  ADDR_W  word address.
- `wdata0`, `wdata1`  in  DATA_W  write data.
- `gnt0`, `gnt1`  out  1  one-cycle pulse; the request is being executed this cycle.
- `rdata0`, `rdata1`  out  DATA_W  read data, registered; holds its value until the next read by the same requester.
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse; `rdataN` is valid.
- `ram_cs`, `ram_re`, `ram_we`  out  1  RAM strobes, registered.
- `ram_addr`  out  ADDR_W  RAM address, registered.
- `ram_wdata`  out  DATA_W  RAM write data, registered.
- `ram_rdata`  in  DATA_W  RAM read data; combinational from the registered strobes and address.
- `busy`  out  1  high while state is ACCESS.
- `conflict_cnt`  out  16  number of arbitrations in which both requesters were active; saturates at 0xFFFF.

## Operation
- FSM has two states, IDLE and ACCESS. The reset state is IDLE.
- **IDLE, no request:** stay in IDLE. All RAM strobes are 0.
- **IDLE, any `reqN` high:**
  - Choose the winner.
  - Latch the winner's `we`, `addr` and `wdata` into `ram_*`.
  - Set `ram_cs`=1, `ram_re`=~we and `ram_we`=we.
  - Register `gntN`=1 and move to ACCESS.
- **ACCESS, always:**
  - Clear `gnt` and all RAM strobes.
  - For a read, capture `ram_rdata` into the winner's `rdataN` and set `rvalidN`=1 for one cycle.
  - Return to IDLE.
- **Arbitration:**
  - A single request always wins.
  - On contention, the winner is the requester not recorded in `last`; `last` is then updated to the winner.
  - `last` resets to 1, so requester 0 wins the first contention.
  - Each contention increments `conflict_cnt` (saturating).
- **Requests are not pipelined.** A `req` still high in the IDLE cycle after its `gnt` is treated as a new request.
- **Reset values:**
  - All `gnt`, `rvalid` and `ram_*` strobes are 0; `busy`=0.
  - `ram_addr`, `ram_wdata`, `rdata0` and `rdata1` are 0.
  - `conflict_cnt`=0; `last`=1; state is IDLE.
- **Reset during ACCESS:** the access is abandoned. No `rvalid` is produced and the strobes are 0 in the cycle after the reset edge. A write already presented during the ACCESS cycle may have completed in the RAM.

## Timing
- Request sampled in IDLE at cycle N:
  - Cycle N+1: `gntN`, RAM strobes and `busy` are high.
  - Cycle N+2: `rvalidN` is high for a read, and `rdataN` shows the value.
- Read latency from request to data is 2 cycles. Throughput is one access per 2 cycles.
- With both requesters held continuously, grants alternate: 0, 1, 0, 1 … each 2 cycles apart.
- The earliest re-request from the same master is sampled at cycle N+2.
- `rvalid` for an access coincides with the IDLE cycle in which the next request is sampled.

## Configuration
- `ARB_FIXED_PRIO_EN`:
  - **Defined:** requester 0 always wins a contention. `last` is unused, and requester 1 is served only when `req0`=0 in the sampling cycle. `conflict_cnt` still counts contentions.
  - **Undefined (default):** round-robin as specified in Operation.

## Test plan
- **Single read.** RAM[0x10]=0xBEEF; `req0`, `we0`=0, `addr0`=0x10 at cycle N → `gnt0`, `ram_cs`=1, `ram_re`=1, `ram_addr`=0x10 at N+1; `rvalid0`=1, `rdata0`=0xBEEF at N+2; `rvalid1`=0 throughout.
- **Single write.** `req1`, `we1`=1, `addr1`=0x22, `wdata1`=0x1234 → `gnt1`, `ram_we`=1, `ram_wdata`=0x1234 at N+1; no `rvalid1`; a later read of 0x22 by requester 0 returns 0x1234.
- **Contention, round-robin.** Both requesters hold reads for 8 cycles → grants 0, 1, 0, 1 at 2-cycle spacing; `conflict_cnt`=4.
- **Contention, `ARB_FIXED_PRIO_EN` defined.** Same stimulus → four `gnt0` and zero `gnt1`; after `req0` drops, `gnt1` follows within 2 cycles.
- **Reset mid-access.** Assert `rst` during the ACCESS cycle of a read → next cycle has all outputs at reset values, no `rvalid0`, and `conflict_cnt`=0.
- **Counter saturation.** Preload with 65535 contentions, then add 2 more → `conflict_cnt`=0xFFFF and no wrap.
